// File: rtl/pwd_pkg.sv
// Shared definitions for the password stream mux slice.
//   - state_e     : arbitration / lock FSM states
//   - DATA_W_DEFAULT : default byte width of every stream
//   - CH_KEYPAD / CH_STORED : channel identifiers carried on out_sel
package pwd_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic CH_KEYPAD = 1'b0;
  localparam logic CH_STORED = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK0,
    ST_LOCK1,
    ST_FLUSH0,
    ST_FLUSH1
  } state_e;

endpackage

// File: rtl/pwd_out_reg.sv
// Single-entry output register with valid/ready handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_i            : capture data_i/sel_i/last_i/err_i this cycle
//   data_i..err_i     : beat to capture
//   ready_i           : downstream accepts the held beat
//   can_load_o        : register is empty or draining this cycle
//   valid_o..err_o    : held beat
module pwd_out_reg
  import pwd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sel_i,
  input  logic              last_i,
  input  logic              err_i,
  input  logic              ready_i,
  output logic              can_load_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sel_o,
  output logic              last_o,
  output logic              err_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              sel_q;
  logic              last_q;
  logic              err_q;

  // Load and drain may coincide, giving one beat per cycle.
  assign can_load_o = !valid_q || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      sel_q   <= sel_i;
      last_q  <= last_i;
      err_q   <= err_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign last_o  = last_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pwd_stream_mux.sv
// Merges keypad (ch0) and stored-password (ch1) byte streams into one
// tagged stream. Packet-locked round-robin grant, one registered output
// stage, and a length guard that truncates packets longer than MAX_LEN.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   inK_valid/data/last/ready  : input channel K handshake (K = 0, 1)
//   out_valid/data/ready       : output handshake
//   out_sel                    : source channel of the beat
//   out_last / out_err         : end of packet / truncated end of packet
module pwd_stream_mux
  import pwd_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  output logic              out_last,
  output logic              out_err,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              last_served_q, last_served_d;

  logic              lock_ch;
  logic              ch_valid;
  logic [DATA_W-1:0] ch_data;
  logic              ch_last;

  logic              can_load;
  logic              load;
  logic [DATA_W-1:0] ld_data;
  logic              ld_sel;
  logic              ld_last;
  logic              ld_err;

  // Locked channel view; only meaningful in LOCK states.
  assign lock_ch  = (state_q == ST_LOCK1);
  assign ch_valid = lock_ch ? in1_valid : in0_valid;
  assign ch_data  = lock_ch ? in1_data  : in0_data;
  assign ch_last  = lock_ch ? in1_last  : in0_last;
  assign cnt_inc  = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_served_q <= CH_STORED;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    in0_ready     = 1'b0;
    in1_ready     = 1'b0;
    load          = 1'b0;
    ld_data       = ch_data;
    ld_sel        = lock_ch;
    ld_last       = ch_last;
    ld_err        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = (last_served_q == CH_KEYPAD) ? ST_LOCK1 : ST_LOCK0;
        end else if (in0_valid) begin
          state_d = ST_LOCK0;
        end else if (in1_valid) begin
          state_d = ST_LOCK1;
        end
      end

      ST_LOCK0, ST_LOCK1: begin
        // Ready tracks output space only, never the source's valid.
        if (lock_ch) in1_ready = can_load;
        else         in0_ready = can_load;

        if (ch_valid && can_load) begin
          load  = 1'b1;
          cnt_d = cnt_inc;
          if (ch_last) begin
            cnt_d         = '0;
            last_served_d = lock_ch;
            state_d       = ST_IDLE;
          end else if (cnt_inc == MAX_CNT) begin
            // Runaway packet: close it here and swallow the remainder.
            ld_last       = 1'b1;
            ld_err        = 1'b1;
            cnt_d         = '0;
            last_served_d = lock_ch;
            state_d       = lock_ch ? ST_FLUSH1 : ST_FLUSH0;
          end
        end
      end

      ST_FLUSH0: begin
        in0_ready = 1'b1;
        if (in0_valid && in0_last) state_d = ST_IDLE;
      end

      ST_FLUSH1: begin
        in1_ready = 1'b1;
        if (in1_valid && in1_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  pwd_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .data_i    (ld_data),
    .sel_i     (ld_sel),
    .last_i    (ld_last),
    .err_i     (ld_err),
    .ready_i   (out_ready),
    .can_load_o(can_load),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .sel_o     (out_sel),
    .last_o    (out_last),
    .err_o     (out_err)
  );

endmodule

// File: doc/pwd_stream_mux.md
Name: pwd_stream_mux

Overview:
- Merges two 8-bit password byte streams into one tagged stream for the checker datapath. Channel 0 is keypad entry; channel 1 is stored-password readback.
- It is the inverse of the byte-steering demux at the checker input.
- Uses packet-locked round-robin arbitration, one registered output stage, and a length guard that truncates runaway packets.

Parameters:
- DATA_W, 8, byte width of each channel and of the output.
- MAX_LEN, 16, maximum number of beats per packet before forced truncation; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in0_valid  in  1  channel 0 beat valid
- in0_data  in  DATA_W  channel 0 byte
- in0_last  in  1  channel 0 final beat of packet
- in0_ready  out  1  channel 0 beat accepted when valid&ready
- in1_valid, in1_data, in1_last, in1_ready: same as channel 0, for channel 1
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  output byte
- out_sel  out  1  source channel of the beat
- out_last  out  1  final beat of the output packet
- out_err  out  1  beat is a truncated last (length overflow)
- out_ready  in  1  downstream accepts when out_valid&out_ready

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_data, out_sel, out_last, out_err = 0
  - state = IDLE, beat count = 0, last_served = 1
- FSM states: IDLE, LOCK0, LOCK1, FLUSH0, FLUSH1.
- IDLE:
  - in0_ready = in1_ready = 0.
  - If exactly one inX_valid, go to LOCKX next cycle.
  - If both are valid, grant the channel != last_served.
  - If neither is valid, stay in IDLE.
  - The grant costs one cycle; no beat is accepted in IDLE.
- LOCKk:
  - in_k_ready = (!out_valid | out_ready). The other channel's ready is 0.
  - On an accepted beat, the output register loads data, sel=k, last=in_last, err=0, and count increments.
  - If the accepted beat has last=1: count clears, last_served = k, go to IDLE.
  - If the accepted beat has last=0 and count reaches MAX_LEN: force out_last=1, out_err=1, count clears, last_served = k, go to FLUSHk.
- FLUSHk:
  - in_k_ready = 1 unconditionally; beats are dropped and never reach the output.
  - Leave for IDLE after the beat with last=1.
  - If that last=1 beat is the first one seen in FLUSHk, it is still dropped.
- Output register:
  - out_valid sets on load and clears on (out_valid & out_ready & no new load).
  - Load and drain in the same cycle are allowed, giving full throughput of 1 beat per cycle while locked.
  - Latency is 1 cycle from input acceptance to out_valid.
  - Data, sel, last and err hold stable while out_valid & !out_ready.
- Backpressure: in_k_ready combinationally follows out_ready. There is no combinational path from in*_valid to in*_ready.
- A source dropping valid mid-packet keeps the lock; there is no timeout.
- A single-beat packet (last on the first beat) goes LOCK → IDLE with count = 0.
- Reset mid-packet discards the held beat and the lock. Upstream must restart its packet.
- in*_data and in*_last are don't-care while valid=0.

Decomposition:
- Shared package pwd_pkg holds:
  - the state enum
  - DATA_W default
  - the channel id constants CH_KEYPAD=0 and CH_STORED=1
- One natural sub-module: pwd_out_reg, the single-entry output register with load/drain handshake.
- Arbitration, FSM and length counter stay in the top module.

Test Plan:
- Reset, then in0 sends 0x31,0x32,0x33(last) with out_ready=1:
  - IDLE→LOCK0 after 1 cycle.
  - Output is 0x31,0x32,0x33 on consecutive cycles, sel=0, last on 0x33, err=0.
  - in1_ready stays 0 throughout.
- in0 and in1 valid in the same cycle after reset:
  - Channel 0 is served first.
  - Channel 1's packet follows after in0's last plus one IDLE cycle.
  - With both still pending afterwards, grant returns to channel 0.
- out_ready held 0 for 3 cycles mid-packet:
  - out_data stays frozen.
  - in0_ready = 0.
  - No beat is lost or duplicated after release.
- MAX_LEN=4 and in1 sends 6 beats 0xA0..0xA5 with last on 0xA5:
  - Output is 0xA0..0xA3; 0xA3 carries last=1, err=1.
  - 0xA4 and 0xA5 are consumed and dropped; then IDLE.
- Single-beat packet 0x7F(last) on in1: one output beat with last=1, count back to 0.
- Assert rst_n low while out_valid=1 in LOCK1:
  - All outputs are 0 immediately (asynchronous).
  - After release, state = IDLE and channel 0 has priority.
